// File: rtl/full_adder_if.sv
// full_adder_if: operand/result bundle for full_adder; master drives operands, slave returns results.
interface full_adder_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] A, B, Sum;
    logic Cin, in_valid, Cout, Ovf, out_valid;
    logic [CNT_W-1:0] carry_cnt;
    modport master (output A, B, Cin, in_valid, input Sum, Cout, Ovf, out_valid, carry_cnt);
    modport slave (input A, B, Cin, in_valid, output Sum, Cout, Ovf, out_valid, carry_cnt);
endinterface

// File: rtl/full_adder.sv
// full_adder: registered WIDTH-bit ripple-carry adder with signed-overflow flag and saturating carry counter.
// Define FULL_ADDER_COMB_EN for a zero-latency combinational datapath; the counter stays clocked.
module full_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    full_adder_if.slave bus
);
    logic [WIDTH:0] c;
    logic [WIDTH-1:0] s;
    logic ovf;
    logic [CNT_W-1:0] cnt;
    assign c[0] = bus.Cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign s[i] = bus.A[i] ^ bus.B[i] ^ c[i];
        assign c[i+1] = (bus.A[i] & bus.B[i]) | (bus.A[i] & c[i]) | (bus.B[i] & c[i]);
    end
    assign ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) & (s[WIDTH-1] != bus.A[WIDTH-1]);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (bus.in_valid && c[WIDTH] && !(&cnt)) cnt <= cnt + CNT_W'(1);
    assign bus.carry_cnt = cnt;
`ifdef FULL_ADDER_COMB_EN
    assign bus.Sum = s;
    assign bus.Cout = c[WIDTH];
    assign bus.Ovf = ovf;
    assign bus.out_valid = bus.in_valid;
`else
    logic [WIDTH-1:0] sum_q;
    logic cout_q, ovf_q, vld_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sum_q <= '0;
            cout_q <= 1'b0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q <= s;
                cout_q <= c[WIDTH];
                ovf_q <= ovf;
            end
        end
    assign bus.Sum = sum_q;
    assign bus.Cout = cout_q;
    assign bus.Ovf = ovf_q;
    assign bus.out_valid = vld_q;
`endif
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: table vectors, random stimulus against an arithmetic model, valid gating, async reset, saturation.
module tb_full_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] es[2];
    logic ec[2], eo[2], ev[2];
    int ecnt[2];

    full_adder_if #(.WIDTH(1), .CNT_W(8)) f1();
    full_adder_if #(.WIDTH(8), .CNT_W(8)) f8();
    full_adder #(.WIDTH(1), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(f1));
    full_adder #(.WIDTH(8), .CNT_W(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(f8));

    always #5 clk = ~clk;

    typedef struct {
        int w;
        logic [7:0] a, b;
        logic cin;
        logic [7:0] s;
        logic co, ov;
    } vec_t;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Plain-integer reference: unsigned sum for Sum/Cout, signed range test for Ovf.
    task automatic model(input int w, input logic [7:0] a, input logic [7:0] b, input logic cin,
                         output logic [7:0] s, output logic co, output logic ov);
        int mask, r, sa, sb, sr;
        mask = (1 << w) - 1;
        r = (int'(a) & mask) + (int'(b) & mask) + int'(cin);
        s = 8'(r & mask);
        co = ((r >> w) & 1) != 0;
        sa = a[w-1] ? (int'(a) & mask) - (1 << w) : (int'(a) & mask);
        sb = b[w-1] ? (int'(b) & mask) - (1 << w) : (int'(b) & mask);
        sr = sa + sb + int'(cin);
        ov = (sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1)));
    endtask

    task automatic predict(input int k, input int w, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic v);
        logic [7:0] s;
        logic co, ov;
        model(w, a, b, cin, s, co, ov);
        if (v) begin
            es[k] = s;
            ec[k] = co;
            eo[k] = ov;
            if (co && ecnt[k] < 255) ecnt[k]++;
        end
        ev[k] = v;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sum1"}, 64'(f1.Sum), 64'(es[0][0]));
        chk({tag, ".cout1"}, 64'(f1.Cout), 64'(ec[0]));
        chk({tag, ".ovf1"}, 64'(f1.Ovf), 64'(eo[0]));
        chk({tag, ".vld1"}, 64'(f1.out_valid), 64'(ev[0]));
        chk({tag, ".cnt1"}, 64'(f1.carry_cnt), 64'(ecnt[0]));
        chk({tag, ".sum8"}, 64'(f8.Sum), 64'(es[1]));
        chk({tag, ".cout8"}, 64'(f8.Cout), 64'(ec[1]));
        chk({tag, ".ovf8"}, 64'(f8.Ovf), 64'(eo[1]));
        chk({tag, ".vld8"}, 64'(f8.out_valid), 64'(ev[1]));
        chk({tag, ".cnt8"}, 64'(f8.carry_cnt), 64'(ecnt[1]));
    endtask

    task automatic tick(input string tag);
        predict(0, 1, 8'(f1.A), 8'(f1.B), f1.Cin, f1.in_valid);
        predict(1, 8, f8.A, f8.B, f8.Cin, f8.in_valid);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            es[k] = '0;
            ec[k] = 1'b0;
            eo[k] = 1'b0;
            ev[k] = 1'b0;
            ecnt[k] = 0;
        end
    endtask

    task automatic drive(input logic [7:0] a1, input logic [7:0] b1, input logic c1, input logic v1,
                         input logic [7:0] a8, input logic [7:0] b8, input logic c8, input logic v8);
        f1.A = a1[0];
        f1.B = b1[0];
        f1.Cin = c1;
        f1.in_valid = v1;
        f8.A = a8;
        f8.B = b8;
        f8.Cin = c8;
        f8.in_valid = v8;
    endtask

    initial begin
        vec_t tbl[10];
        tbl[0] = '{1, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};
        tbl[1] = '{1, 8'd0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1};
        tbl[2] = '{1, 8'd0, 8'd1, 1'b0, 8'd1, 1'b0, 1'b0};
        tbl[3] = '{1, 8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0};
        tbl[4] = '{1, 8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
        tbl[5] = '{1, 8'd1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0};
        tbl[6] = '{1, 8'd1, 8'd1, 1'b0, 8'd0, 1'b1, 1'b1};
        tbl[7] = '{1, 8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0};
        tbl[8] = '{8, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[9] = '{8, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        clear_model();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_all("reset");
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].w == 1) drive(tbl[i].a, tbl[i].b, tbl[i].cin, 1, 0, 0, 0, 0);
            else drive(0, 0, 0, 0, tbl[i].a, tbl[i].b, tbl[i].cin, 1);
            tick($sformatf("tbl%0d", i));
            if (tbl[i].w == 1) begin
                chk($sformatf("tbl%0d.sum", i), 64'(f1.Sum), 64'(tbl[i].s[0]));
                chk($sformatf("tbl%0d.cout", i), 64'(f1.Cout), 64'(tbl[i].co));
                chk($sformatf("tbl%0d.ovf", i), 64'(f1.Ovf), 64'(tbl[i].ov));
            end else begin
                chk($sformatf("tbl%0d.sum", i), 64'(f8.Sum), 64'(tbl[i].s));
                chk($sformatf("tbl%0d.cout", i), 64'(f8.Cout), 64'(tbl[i].co));
                chk($sformatf("tbl%0d.ovf", i), 64'(f8.Ovf), 64'(tbl[i].ov));
            end
        end

        // u1 last captured 1+1+1 -> Sum=1, Cout=1; an invalid 1+1 must not disturb it.
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        tick("gate0");
        chk("gate0.vld", 64'(f1.out_valid), 64'd0);
        chk("gate0.sum", 64'(f1.Sum), 64'd1);
        chk("gate0.cout", 64'(f1.Cout), 64'd1);
        f1.in_valid = 1'b1;
        tick("gate1");
        chk("gate1.sum", 64'(f1.Sum), 64'd0);
        chk("gate1.cout", 64'(f1.Cout), 64'd1);
        chk("gate1.vld", 64'(f1.out_valid), 64'd1);

        for (int i = 0; i < 200; i++) begin
            drive(8'($urandom_range(1, 0)), 8'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  ($urandom % 4) != 0, 8'($urandom), 8'($urandom), 1'($urandom_range(1, 0)),
                  ($urandom % 4) != 0);
            tick($sformatf("rnd%0d", i));
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b0;
        clear_model();
        #1;
        check_all("rst0");
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 1, 0, 0, 0, 0);
            tick($sformatf("pre%0d", i));
        end
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        tick("pre5");
        chk("pre.sum", 64'(f1.Sum), 64'd1);
        chk("pre.cnt", 64'(f1.carry_cnt), 64'd5);
        #3 rst_n = 1'b0;
        clear_model();
        #1;
        check_all("arst");
        chk("arst.sum", 64'(f1.Sum), 64'd0);
        chk("arst.cnt", 64'(f1.carry_cnt), 64'd0);
        #2 rst_n = 1'b1;
        #1;
        check_all("arst_rel");
        drive(1, 0, 1, 1, 0, 0, 0, 0);
        tick("post");
        chk("post.sum", 64'(f1.Sum), 64'd0);
        chk("post.cout", 64'(f1.Cout), 64'd1);

        drive(1, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) tick($sformatf("sat%0d", i));
        chk("sat.cnt", 64'(f1.carry_cnt), 64'd255);
        tick("sat_hold");
        chk("sat_hold.cnt", 64'(f1.carry_cnt), 64'd255);
        chk("sat_hold.sum", 64'(f1.Sum), 64'd0);
        chk("sat_hold.cout", 64'(f1.Cout), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
